spi_slave: RTL and testbench

- Synchronous SPI responder; the far end of the SPI master on the MOSI/MISO/SCLK/SS lines.
- Oversamples the master's SCLK, SS_N and MOSI on the local system clock.
- Receives full-duplex words into RX_DATA and shifts TX words out on MISO.
- Supports all four CPOL/CPHA modes; exchanges data with local logic over a valid/ready TX interface and a one-cycle RX_VALID pulse.

---
 rtl/spi_slave.sv | 176 +++++++++++++++++
 tb/tb_spi_slave.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI responder running entirely in the local CLK domain.
// SCLK, SS_N and MOSI are oversampled through 2-FF synchronizers. Edges are
// found by comparing against a one-cycle delayed copy, so a pin change is
// acted on 3 CLK cycles after it happens. All four CPOL/CPHA modes are
// supported, and the mode is latched at frame start.
//
// Ports:
//   CLK, RST_N            system clock, async active-low reset
//   CPOL_IN, CPHA_IN      SPI mode, captured when SS_N falls
//   SCLK, SS_N, MOSI      master lines (asynchronous)
//   MISO, MISO_OE         serial data out and its drive enable
//   TX_DATA/VALID/READY   one-deep transmit holding register (valid/ready)
//   RX_DATA, RX_VALID     last complete word and its 1-cycle strobe
//   TX_UNDERRUN           1-cycle pulse: a word started with nothing queued
//   FRAME_ERR             1-cycle pulse: SS_N released mid-word
module spi_slave #(
    parameter int               WIDTH      = 8,
    parameter bit               LSB_FIRST  = 1'b1,
    parameter logic [WIDTH-1:0] TX_DEFAULT = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CPOL_IN,
    input  logic             CPHA_IN,
    input  logic             SCLK,
    input  logic             SS_N,
    input  logic             MOSI,
    output logic             MISO,
    output logic             MISO_OE,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic             TX_UNDERRUN,
    output logic             FRAME_ERR
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    state_t state, state_nxt;

    // [0],[1] form the synchronizer. [2] is the delayed copy used for edge detection.
    logic [2:0]       sclk_s, ss_s;
    logic [1:0]       mosi_s;
    logic             cpol_q, cpha_q;
    logic [CW-1:0]    bit_cnt;
    logic             reload_pend;   // a word finished; next shift edge loads the next one
    logic [WIDTH-1:0] tx_shift, rx_shift, hold_data;
    logic             hold_full;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_s <= '0;
            ss_s   <= '1;            // deselected, so reset release shows no false SS_N fall
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], SCLK};
            ss_s   <= {ss_s[1:0], SS_N};
            mosi_s <= {mosi_s[0], MOSI};
        end
    end

    logic active, ss_fall, ss_rise, sclk_edge, lead, trail;
    logic sample_edge, shift_edge, start, reload, take;

    assign active    = (state == ACTIVE);
    assign ss_fall   = ss_s[2] & ~ss_s[1];
    assign ss_rise   = ~ss_s[2] & ss_s[1];
    assign sclk_edge = sclk_s[2] ^ sclk_s[1];
    assign lead      = sclk_edge & (sclk_s[1] != cpol_q);
    assign trail     = sclk_edge & (sclk_s[1] == cpol_q);
    // A deselect in the same cycle as an SCLK edge kills that edge.
    assign sample_edge = active & ~ss_rise & (cpha_q ? trail : lead);
    assign shift_edge  = active & ~ss_rise & (cpha_q ? lead : trail);
    assign start       = ~active & ss_fall;
    // A shift edge at count 0 marks a word boundary. It reloads after a
    // finished word. Otherwise it is the CPHA=1 first leading edge and is ignored.
    assign reload      = shift_edge & (bit_cnt == '0) & reload_pend;
    assign take        = start | reload;

    // FSM: state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        MISO_OE = active;
        MISO    = 1'b0;
        if (active) MISO = LSB_FIRST ? tx_shift[0] : tx_shift[WIDTH-1];
    end

    logic [WIDTH-1:0] rx_nxt, tx_adv;
    assign rx_nxt = LSB_FIRST ? {mosi_s[1], rx_shift[WIDTH-1:1]} : {rx_shift[WIDTH-2:0], mosi_s[1]};
    assign tx_adv = LSB_FIRST ? {1'b0, tx_shift[WIDTH-1:1]}      : {tx_shift[WIDTH-2:0], 1'b0};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            RX_DATA     <= '0;
            RX_VALID    <= 1'b0;
            TX_UNDERRUN <= 1'b0;
            FRAME_ERR   <= 1'b0;
        end else begin
            RX_VALID    <= 1'b0;
            TX_UNDERRUN <= 1'b0;
            FRAME_ERR   <= 1'b0;
            if (start) begin
                cpol_q      <= CPOL_IN;
                cpha_q      <= CPHA_IN;
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end
            if (take) begin
                tx_shift    <= hold_full ? hold_data : TX_DEFAULT;
                TX_UNDERRUN <= ~hold_full;
                if (reload) reload_pend <= 1'b0;
            end else if (shift_edge && bit_cnt != '0) begin
                tx_shift <= tx_adv;
            end
            if (sample_edge) begin
                rx_shift <= rx_nxt;
                if (bit_cnt == LAST) begin
                    bit_cnt     <= '0;
                    reload_pend <= 1'b1;
                    RX_DATA     <= rx_nxt;
                    RX_VALID    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
            // A partial word is dropped. rx_shift is fully overwritten by the next word.
            if (active && ss_rise) begin
                FRAME_ERR   <= (bit_cnt != '0);
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end
        end
    end

    // Holding register. A reload in the same cycle as a load takes the old
    // contents, and the newly accepted word stays queued.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else begin
            if (take && hold_full) hold_full <= 1'b0;
            if (TX_VALID && TX_READY) begin
                hold_full <= 1'b1;
                hold_data <= TX_DATA;
            end
        end
    end

    assign TX_READY = ~hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master plus a word-level model.
// Expected MISO is the queued word (or 0 when nothing is queued), sent bit 0 first.
// Expected RX is the word the master sent. Underruns are word loads minus queued words.
module tb_spi_slave;
    localparam int W    = 8;
    localparam int HALF = 8;   // CLK cycles per SCLK half period

    logic         CLK = 0, RST_N = 0, CPOL_IN = 0, CPHA_IN = 0;
    logic         SCLK = 0, SS_N = 1, MOSI = 0, TX_VALID = 0;
    logic [W-1:0] TX_DATA = '0;
    logic         MISO, MISO_OE, TX_READY, RX_VALID, TX_UNDERRUN, FRAME_ERR;
    logic [W-1:0] RX_DATA;

    int n_vec = 0, n_err = 0;
    int rxv_cnt = 0, und_cnt = 0, ferr_cnt = 0;
    logic [W-1:0] rxq[$];

    spi_slave #(.WIDTH(W), .LSB_FIRST(1'b1), .TX_DEFAULT('0)) dut (
        .CLK(CLK), .RST_N(RST_N), .CPOL_IN(CPOL_IN), .CPHA_IN(CPHA_IN),
        .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .TX_UNDERRUN(TX_UNDERRUN),
        .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    // Pulse monitor. Tests only read snapshots of these counters.
    always @(negedge CLK) begin
        if (RX_VALID) begin
            rxv_cnt = rxv_cnt + 1;
            rxq.push_back(RX_DATA);
        end
        if (TX_UNDERRUN) und_cnt = und_cnt + 1;
        if (FRAME_ERR)   ferr_cnt = ferr_cnt + 1;
    end

    // Behavioural master: asserts SS_N and runs nbits SCLK periods. It does not release SS_N.
    task automatic frame(input bit cpol, input bit cpha, input logic [15:0] mo,
                         input int nbits, output logic [15:0] mi);
        mi = '0;
        CPOL_IN = cpol; CPHA_IN = cpha; SCLK = cpol;
        repeat (6) @(negedge CLK);
        SS_N = 1'b0;
        repeat (HALF) @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                MOSI = mo[i];
                repeat (HALF) @(negedge CLK);
                mi[i] = MISO;
                SCLK = ~cpol;
                repeat (HALF) @(negedge CLK);
                SCLK = cpol;
            end else begin
                SCLK = ~cpol;
                MOSI = mo[i];
                repeat (HALF) @(negedge CLK);
                mi[i] = MISO;
                SCLK = cpol;
                repeat (HALF) @(negedge CLK);
            end
        end
        repeat (HALF) @(negedge CLK);
    endtask

    // Releases SS_N and reports the cycle count until MISO_OE drops (-1 means never).
    task automatic ss_release(output int lat);
        SS_N = 1'b1;
        lat = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            if (lat < 0 && !MISO_OE) lat = c;
        end
    endtask

    task automatic push_tx(input logic [W-1:0] d, output bit ok);
        int t;
        t = 0;
        while (!TX_READY && t < 400) begin
            @(negedge CLK);
            t++;
        end
        ok = TX_READY;
        if (ok) begin
            TX_DATA = d; TX_VALID = 1'b1;
            @(negedge CLK);
            TX_VALID = 1'b0;
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        n_vec++; if (MISO !== 1'b0)      begin n_err++; $display("FAIL reset_miso: got %b want 0", MISO); end
        n_vec++; if (MISO_OE !== 1'b0)   begin n_err++; $display("FAIL reset_oe: got %b want 0", MISO_OE); end
        n_vec++; if (RX_DATA !== 8'h00)  begin n_err++; $display("FAIL reset_rxdata: got %h want 00", RX_DATA); end
        n_vec++; if (RX_VALID !== 1'b0)  begin n_err++; $display("FAIL reset_rxvalid: got %b want 0", RX_VALID); end
        n_vec++; if (TX_READY !== 1'b1)  begin n_err++; $display("FAIL reset_txready: got %b want 1", TX_READY); end
        n_vec++; if (TX_UNDERRUN !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b want 0", TX_UNDERRUN); end
        n_vec++; if (FRAME_ERR !== 1'b0) begin n_err++; $display("FAIL reset_frameerr: got %b want 0", FRAME_ERR); end
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_mode0;
        logic [15:0] mi; bit ok; int lat, r0, q0;
        push_tx(8'hA5, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL m0_push: got timeout want accepted"); end
        n_vec++; if (TX_READY !== 1'b0) begin n_err++; $display("FAIL m0_ready_low: got %b want 0", TX_READY); end
        r0 = rxv_cnt; q0 = rxq.size();
        frame(1'b0, 1'b0, 16'h003C, 8, mi);
        ss_release(lat);
        n_vec++; if (mi[7:0] !== 8'hA5) begin n_err++; $display("FAIL m0_miso: got %h want a5", mi[7:0]); end
        n_vec++; if (rxv_cnt - r0 != 1) begin n_err++; $display("FAIL m0_rxvalid_cnt: got %0d want 1", rxv_cnt - r0); end
        n_vec++; if (rxq.size() <= q0 || rxq[q0] !== 8'h3C) begin n_err++; $display("FAIL m0_rxword: got %h want 3c", RX_DATA); end
        n_vec++; if (TX_READY !== 1'b1) begin n_err++; $display("FAIL m0_ready_high: got %b want 1", TX_READY); end
        n_vec++; if (lat < 1 || lat > 4) begin n_err++; $display("FAIL m0_oe_drop: got %0d cycles want 1..4", lat); end
    endtask

    task automatic test_mode3;
        logic [15:0] mi; bit ok; int lat, r0, u0;
        push_tx(8'h5A, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL m3_push: got timeout want accepted"); end
        r0 = rxv_cnt; u0 = und_cnt;
        frame(1'b1, 1'b1, 16'h00FF, 8, mi);
        ss_release(lat);
        n_vec++; if (mi[7:0] !== 8'h5A)  begin n_err++; $display("FAIL m3_miso: got %h want 5a", mi[7:0]); end
        n_vec++; if (RX_DATA !== 8'hFF)  begin n_err++; $display("FAIL m3_rxdata: got %h want ff", RX_DATA); end
        n_vec++; if (rxv_cnt - r0 != 1)  begin n_err++; $display("FAIL m3_rxvalid_cnt: got %0d want 1", rxv_cnt - r0); end
        n_vec++; if (und_cnt - u0 != 0)  begin n_err++; $display("FAIL m3_underrun: got %0d want 0", und_cnt - u0); end
    endtask

    task automatic test_underrun;
        logic [15:0] mi; int lat, u0;
        u0 = und_cnt;
        frame(1'b0, 1'b1, 16'h0081, 8, mi);
        ss_release(lat);
        n_vec++; if (und_cnt - u0 != 1)  begin n_err++; $display("FAIL ur_pulses: got %0d want 1", und_cnt - u0); end
        n_vec++; if (mi[7:0] !== 8'h00)  begin n_err++; $display("FAIL ur_miso: got %h want 00", mi[7:0]); end
        n_vec++; if (RX_DATA !== 8'h81)  begin n_err++; $display("FAIL ur_rxdata: got %h want 81", RX_DATA); end
    endtask

    task automatic test_abort;
        logic [15:0] mi; logic [7:0] tx, rx; bit ok; int lat, r0, f0;
        r0 = rxv_cnt; f0 = ferr_cnt;
        frame(1'b1, 1'b0, 16'($urandom_range(0, 255)), 3, mi);
        ss_release(lat);
        n_vec++; if (ferr_cnt - f0 != 1) begin n_err++; $display("FAIL ab_frameerr: got %0d want 1", ferr_cnt - f0); end
        n_vec++; if (rxv_cnt - r0 != 0)  begin n_err++; $display("FAIL ab_rxvalid: got %0d want 0", rxv_cnt - r0); end
        n_vec++; if (lat < 1 || lat > 4) begin n_err++; $display("FAIL ab_oe_drop: got %0d cycles want 1..4", lat); end
        n_vec++; if (RX_DATA !== 8'h81)  begin n_err++; $display("FAIL ab_rx_kept: got %h want 81", RX_DATA); end
        tx = 8'($urandom_range(0, 255)); rx = 8'($urandom_range(0, 255));
        push_tx(tx, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL ab_push: got timeout want accepted"); end
        frame(1'b1, 1'b0, {8'h00, rx}, 8, mi);
        ss_release(lat);
        n_vec++; if (RX_DATA !== rx)     begin n_err++; $display("FAIL ab_next_rx: got %h want %h", RX_DATA, rx); end
        n_vec++; if (mi[7:0] !== tx)     begin n_err++; $display("FAIL ab_next_miso: got %h want %h", mi[7:0], tx); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] mi, mo; bit ok1, ok2, cp; int lat, r0, q0, u0;
        for (int ph = 0; ph < 2; ph++) begin
            cp = 1'($urandom_range(0, 1));
            mo = 16'($urandom_range(0, 65535));
            push_tx(8'h11, ok1);
            r0 = rxv_cnt; q0 = rxq.size(); u0 = und_cnt;
            fork
                frame(cp, ph[0], mo, 16, mi);
                push_tx(8'h22, ok2);
            join
            ss_release(lat);
            n_vec++; if (!ok1 || !ok2) begin n_err++; $display("FAIL b2b_push: got %b%b want 11", ok1, ok2); end
            n_vec++; if (mi !== 16'h2211) begin n_err++; $display("FAIL b2b_miso cpha=%0d: got %h want 2211", ph, mi); end
            n_vec++; if (rxv_cnt - r0 != 2) begin n_err++; $display("FAIL b2b_rxvalid cpha=%0d: got %0d want 2", ph, rxv_cnt - r0); end
            n_vec++;
            if (rxq.size() < q0 + 2 || rxq[q0] !== mo[7:0] || rxq[q0+1] !== mo[15:8]) begin
                n_err++; $display("FAIL b2b_rxwords cpha=%0d: got %0d words want %h,%h", ph, rxq.size() - q0, mo[7:0], mo[15:8]);
            end
            // CPHA=0 reloads once more at the last trailing edge and finds nothing queued.
            n_vec++; if (und_cnt - u0 != (ph == 0 ? 1 : 0)) begin n_err++; $display("FAIL b2b_underrun cpha=%0d: got %0d want %0d", ph, und_cnt - u0, (ph == 0 ? 1 : 0)); end
        end
    endtask

    task automatic test_random;
        logic [15:0] mi; logic [7:0] tx, rx, exp_mi; bit cp, ph, q, ok; int lat, r0, u0, exp_u;
        for (int k = 0; k < 12; k++) begin
            cp = 1'($urandom_range(0, 1)); ph = 1'($urandom_range(0, 1)); q = 1'($urandom_range(0, 1));
            tx = 8'($urandom_range(0, 255)); rx = 8'($urandom_range(0, 255));
            ok = 1'b1;
            if (q) push_tx(tx, ok);
            r0 = rxv_cnt; u0 = und_cnt;
            frame(cp, ph, {8'h00, rx}, 8, mi);
            ss_release(lat);
            exp_mi = q ? tx : 8'h00;
            exp_u  = 1 + (ph ? 0 : 1) - (q ? 1 : 0);
            n_vec++; if (!ok || mi[7:0] !== exp_mi) begin n_err++; $display("FAIL rnd%0d_miso mode=%0d%0d: got %h want %h", k, cp, ph, mi[7:0], exp_mi); end
            n_vec++; if (RX_DATA !== rx || rxv_cnt - r0 != 1) begin n_err++; $display("FAIL rnd%0d_rx mode=%0d%0d: got %h x%0d want %h x1", k, cp, ph, RX_DATA, rxv_cnt - r0, rx); end
            n_vec++; if (und_cnt - u0 != exp_u) begin n_err++; $display("FAIL rnd%0d_underrun mode=%0d%0d: got %0d want %0d", k, cp, ph, und_cnt - u0, exp_u); end
        end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] mi; bit ok; int lat, r0, f0;
        frame(1'b0, 1'b0, 16'($urandom_range(0, 255)), 5, mi);
        push_tx(8'h77, ok);
        n_vec++; if (!ok || TX_READY !== 1'b0) begin n_err++; $display("FAIL rm_queue: got ready=%b want 0", TX_READY); end
        r0 = rxv_cnt; f0 = ferr_cnt;
        RST_N = 1'b0; SS_N = 1'b1; SCLK = 1'b0;
        repeat (2) @(negedge CLK);
        n_vec++; if (MISO_OE !== 1'b0 || MISO !== 1'b0) begin n_err++; $display("FAIL rm_miso: got oe=%b miso=%b want 0 0", MISO_OE, MISO); end
        n_vec++; if (RX_DATA !== 8'h00) begin n_err++; $display("FAIL rm_rxdata: got %h want 00", RX_DATA); end
        n_vec++; if (TX_READY !== 1'b1) begin n_err++; $display("FAIL rm_txready: got %b want 1", TX_READY); end
        n_vec++; if (RX_VALID !== 1'b0 || TX_UNDERRUN !== 1'b0 || FRAME_ERR !== 1'b0) begin
            n_err++; $display("FAIL rm_pulses: got %b%b%b want 000", RX_VALID, TX_UNDERRUN, FRAME_ERR);
        end
        RST_N = 1'b1;
        repeat (8) @(negedge CLK);
        n_vec++; if (ferr_cnt - f0 != 0 || rxv_cnt - r0 != 0) begin n_err++; $display("FAIL rm_no_pulse: got ferr=%0d rxv=%0d want 0 0", ferr_cnt - f0, rxv_cnt - r0); end
        frame(1'b0, 1'b0, 16'h00C3, 8, mi);
        ss_release(lat);
        n_vec++; if (RX_DATA !== 8'hC3) begin n_err++; $display("FAIL rm_next_rx: got %h want c3", RX_DATA); end
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_mode3;
        test_underrun;
        test_abort;
        test_back_to_back;
        test_random;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
